// File: rtl/control_sequencer_if.sv
// Interface bundling the sequencer's datapath/memory handshake and control strobes.
// The sequencer connects through the master modport; the datapath side uses slave.
interface control_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 16
);
   logic              run;
   logic [DATA_W-1:0] ir;
   logic              mem_rdy;

   logic              pc_out;
   logic              zlow_out;
   logic              mdr_out;
   logic              mar_in;
   logic              pc_in;
   logic              mdr_in;
   logic              ir_in;
   logic              y_in;
   logic              z_in;
   logic              inc_pc;
   logic              read;
   logic [4:0]        alu_op;
   logic [NREGS-1:0]  reg_out_sel;
   logic [NREGS-1:0]  reg_in_sel;
   logic              halted;
   logic              illegal;
   logic [3:0]        state;

   modport master (
      input  run, ir, mem_rdy,
      output pc_out, zlow_out, mdr_out, mar_in, pc_in, mdr_in, ir_in, y_in, z_in,
             inc_pc, read, alu_op, reg_out_sel, reg_in_sel, halted, illegal, state
   );

   modport slave (
      output run, ir, mem_rdy,
      input  pc_out, zlow_out, mdr_out, mar_in, pc_in, mdr_in, ir_in, y_in, z_in,
             inc_pc, read, alu_op, reg_out_sel, reg_in_sel, halted, illegal, state
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control FSM for the 3-bus datapath: fetch over T0-T2, decode in T3,
// and execute reg-reg ALU ops over T3-T5, with memory wait, NOP, HALT and illegal-op handling.
module control_sequencer #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 16,
   parameter int REG_FW = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   control_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      T0     = 4'd1,
      T1     = 4'd2,
      T2     = 4'd3,
      T3     = 4'd4,
      T4     = 4'd5,
      T5     = 4'd6,
      HALTED = 4'd7
   } stateT;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   stateT state_q, state_d;

   logic [4:0]        op;
   logic [REG_FW-1:0] ra, rb, rc;
   logic              isAlu, isNop, isHalt, regBad, isIllegal;
   logic              unusedIrBits;

   assign op = bus.ir[DATA_W-1 -: 5];
   assign ra = bus.ir[DATA_W-6 -: REG_FW];
   assign rb = bus.ir[DATA_W-6-REG_FW -: REG_FW];
   assign rc = bus.ir[DATA_W-6-2*REG_FW -: REG_FW];
   assign unusedIrBits = ^bus.ir[DATA_W-6-3*REG_FW:0];

   // Out-of-range register fields make any opcode illegal, so illegal wins over HALT/NOP.
   assign isAlu     = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   assign isNop     = (op == OP_NOP);
   assign isHalt    = (op == OP_HALT);
   assign regBad    = (int'(ra) >= NREGS) || (int'(rb) >= NREGS) || (int'(rc) >= NREGS);
   assign isIllegal = !(isAlu || isNop || isHalt) || regBad;

   function automatic logic [NREGS-1:0] oneHot(input logic [REG_FW-1:0] idx);
      return NREGS'(1) << idx;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (bus.run) state_d = T0;
         T0:     state_d = T1;
         T1:     if (bus.mem_rdy) state_d = T2;
         T2:     state_d = T3;
         T3: begin
            if (isIllegal)   state_d = bus.run ? T0 : IDLE;
            else if (isHalt) state_d = HALTED;
            else if (isNop)  state_d = bus.run ? T0 : IDLE;
            else             state_d = T4;
         end
         T4:     state_d = T5;
         T5:     state_d = bus.run ? T0 : IDLE;
         HALTED: state_d = HALTED;
         default: state_d = IDLE;
      endcase
   end

   // pc_in is qualified by mem_rdy so the PC is reloaded exactly once per fetch.
   always_comb begin
      bus.pc_out      = 1'b0;
      bus.zlow_out    = 1'b0;
      bus.mdr_out     = 1'b0;
      bus.mar_in      = 1'b0;
      bus.pc_in       = 1'b0;
      bus.mdr_in      = 1'b0;
      bus.ir_in       = 1'b0;
      bus.y_in        = 1'b0;
      bus.z_in        = 1'b0;
      bus.inc_pc      = 1'b0;
      bus.read        = 1'b0;
      bus.alu_op      = 5'd0;
      bus.reg_out_sel = '0;
      bus.reg_in_sel  = '0;
      bus.halted      = 1'b0;
      bus.illegal     = 1'b0;
      bus.state       = state_q;
      case (state_q)
         T0: begin
            bus.pc_out = 1'b1;
            bus.mar_in = 1'b1;
            bus.inc_pc = 1'b1;
            bus.z_in   = 1'b1;
         end
         T1: begin
            bus.zlow_out = 1'b1;
            bus.read     = 1'b1;
            bus.mdr_in   = 1'b1;
            bus.pc_in    = bus.mem_rdy;
         end
         T2: begin
            bus.mdr_out = 1'b1;
            bus.ir_in   = 1'b1;
         end
         T3: begin
            if (isIllegal) begin
               bus.illegal = 1'b1;
            end else if (isAlu) begin
               bus.reg_out_sel = oneHot(rb);
               bus.y_in        = 1'b1;
            end
         end
         T4: begin
            bus.reg_out_sel = oneHot(rc);
            bus.alu_op      = op;
            bus.z_in        = 1'b1;
         end
         T5: begin
            bus.zlow_out   = 1'b1;
            bus.reg_in_sel = oneHot(ra);
         end
         HALTED: bus.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instruction table, randomized
// trace against a cycle-level expectation model, plus reset/HALT/NREGS=8 corner sequences.
module tb_control_sequencer;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef struct packed {
      logic        pcOut, zlowOut, mdrOut, marIn, pcIn, mdrIn, irIn, yIn, zIn, incPc, read;
      logic [4:0]  aluOp;
      logic [15:0] outSel;
      logic [15:0] inSel;
      logic        halted, illegal;
   } outT;

   typedef struct {
      logic        run;
      logic        memRdy;
      logic [31:0] ir;
      outT         exp;
   } stepT;

   typedef struct {
      logic [31:0] ir;
      int          waits;
      int          cycles;
      logic [15:0] t3Sel;
      logic [15:0] t4Sel;
      logic [4:0]  aluOp;
      logic [15:0] inSel;
      int          pcInCnt;
      int          readCnt;
      int          illegalCnt;
   } vecT;

   logic clk = 1'b0;
   logic reset_n;
   int   testCount = 0;
   int   errCount  = 0;
   int   traceIdx  = 0;
   bit   fsmIdle   = 1'b0;
   stepT plan[$];
   vecT  vecs[8];

   always #5 clk = ~clk;

   control_sequencer_if #(.DATA_W(32), .NREGS(16)) mbus ();
   control_sequencer_if #(.DATA_W(32), .NREGS(8))  sbus ();

   control_sequencer #(.DATA_W(32), .NREGS(16), .REG_FW(4)) dut (
      .clk(clk), .reset_n(reset_n), .bus(mbus)
   );

   control_sequencer #(.DATA_W(32), .NREGS(8), .REG_FW(4)) dut8 (
      .clk(clk), .reset_n(reset_n), .bus(sbus)
   );

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
      return {op, ra, rb, rc, 15'd0};
   endfunction

   function automatic bit isListed(input logic [4:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOP, OP_HALT};
   endfunction

   function automatic outT sampleMain();
      outT o;
      o.pcOut   = mbus.pc_out;
      o.zlowOut = mbus.zlow_out;
      o.mdrOut  = mbus.mdr_out;
      o.marIn   = mbus.mar_in;
      o.pcIn    = mbus.pc_in;
      o.mdrIn   = mbus.mdr_in;
      o.irIn    = mbus.ir_in;
      o.yIn     = mbus.y_in;
      o.zIn     = mbus.z_in;
      o.incPc   = mbus.inc_pc;
      o.read    = mbus.read;
      o.aluOp   = mbus.alu_op;
      o.outSel  = mbus.reg_out_sel;
      o.inSel   = mbus.reg_in_sel;
      o.halted  = mbus.halted;
      o.illegal = mbus.illegal;
      return o;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Cycle-level expectation of one instruction, built straight from the fetch/decode/execute rules.
   task automatic pushStep(input logic r, input logic m, input logic [31:0] i, input outT e);
      stepT s;
      s.run = r; s.memRdy = m; s.ir = i; s.exp = e;
      plan.push_back(s);
   endtask

   task automatic planInstr(input logic [31:0] i, input int waits, input bit dropRun);
      outT        e;
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      logic       r;
      op = i[31:27]; ra = i[26:23]; rb = i[22:19]; rc = i[18:15];
      r  = !dropRun;
      if (fsmIdle) begin
         e = '0;
         pushStep(1'b1, 1'($urandom), i, e);
      end
      e = '0; e.pcOut = 1; e.marIn = 1; e.incPc = 1; e.zIn = 1;
      pushStep(1'b1, 1'($urandom), i, e);
      for (int w = 0; w <= waits; w++) begin
         e = '0; e.zlowOut = 1; e.read = 1; e.mdrIn = 1; e.pcIn = (w == waits);
         pushStep(r, (w == waits), i, e);
      end
      e = '0; e.mdrOut = 1; e.irIn = 1;
      pushStep(r, 1'($urandom), i, e);
      e = '0;
      if (!isListed(op)) begin
         e.illegal = 1;
         pushStep(r, 1'($urandom), i, e);
         fsmIdle = dropRun;
      end else if (op == OP_HALT) begin
         pushStep(r, 1'($urandom), i, e);
         for (int k = 0; k < 3; k++) begin
            e = '0; e.halted = 1;
            pushStep(1'($urandom), 1'($urandom), i, e);
         end
         fsmIdle = 1'b0;
      end else if (op == OP_NOP) begin
         pushStep(r, 1'($urandom), i, e);
         fsmIdle = dropRun;
      end else begin
         e.outSel = 16'd1 << rb; e.yIn = 1;
         pushStep(r, 1'($urandom), i, e);
         e = '0; e.outSel = 16'd1 << rc; e.aluOp = op; e.zIn = 1;
         pushStep(r, 1'($urandom), i, e);
         e = '0; e.zlowOut = 1; e.inSel = 16'd1 << ra;
         pushStep(r, 1'($urandom), i, e);
         fsmIdle = dropRun;
      end
   endtask

   task automatic runPlan();
      stepT s;
      outT  o;
      int   drivers;
      while (plan.size() > 0) begin
         s = plan.pop_front();
         @(negedge clk);
         mbus.run = s.run; mbus.mem_rdy = s.memRdy; mbus.ir = s.ir;
         #1;
         o = sampleMain();
         checkOutput($sformatf("trace%0d", traceIdx), o, s.exp);
         drivers = int'(o.pcOut) + int'(o.zlowOut) + int'(o.mdrOut) + int'(|o.outSel);
         checkOutput($sformatf("oneDriver%0d", traceIdx), 64'(drivers <= 1), 64'd1);
         checkOutput($sformatf("oneHotSel%0d", traceIdx),
                     64'($onehot0(o.outSel) && $onehot0(o.inSel)), 64'd1);
         traceIdx++;
      end
   endtask

   task automatic applyStimulus(input int idx);
      vecT  v;
      outT  o;
      logic [15:0] t3Sel, t4Sel, inSelOr;
      logic [4:0]  aluSeen, aluOther;
      int   pcInCnt, readCnt, illCnt;
      v = vecs[idx];
      t3Sel = '0; t4Sel = '0; inSelOr = '0; aluSeen = '0; aluOther = '0;
      pcInCnt = 0; readCnt = 0; illCnt = 0;
      for (int c = 0; c < v.cycles; c++) begin
         @(negedge clk);
         mbus.ir  = v.ir;
         mbus.run = 1'b1;
         if (c >= 1 && c <= v.waits) mbus.mem_rdy = 1'b0;
         else if (c == v.waits + 1)  mbus.mem_rdy = 1'b1;
         else                        mbus.mem_rdy = 1'($urandom);
         #1;
         o = sampleMain();
         if (c == 0) checkOutput($sformatf("vec%0d_startT0", idx), 64'(o.pcOut & o.marIn & o.incPc), 64'd1);
         if (c == v.waits + 3) t3Sel = o.outSel;
         if (c == v.waits + 4) begin t4Sel = o.outSel; aluSeen = o.aluOp; end
         else aluOther |= o.aluOp;
         inSelOr |= o.inSel;
         pcInCnt += int'(o.pcIn);
         readCnt += int'(o.read);
         illCnt  += int'(o.illegal);
      end
      checkOutput($sformatf("vec%0d_t3Sel", idx),   64'(t3Sel),   64'(v.t3Sel));
      checkOutput($sformatf("vec%0d_t4Sel", idx),   64'(t4Sel),   64'(v.t4Sel));
      checkOutput($sformatf("vec%0d_aluOp", idx),   64'(aluSeen), 64'(v.aluOp));
      checkOutput($sformatf("vec%0d_aluIdle", idx), 64'(aluOther), 64'd0);
      checkOutput($sformatf("vec%0d_inSel", idx),   64'(inSelOr), 64'(v.inSel));
      checkOutput($sformatf("vec%0d_pcIn", idx),    64'(pcInCnt), 64'(v.pcInCnt));
      checkOutput($sformatf("vec%0d_read", idx),    64'(readCnt), 64'(v.readCnt));
      checkOutput($sformatf("vec%0d_illegal", idx), 64'(illCnt),  64'(v.illegalCnt));
   endtask

   initial begin
      logic [4:0] op;
      outT        o;
      int         ill8;
      logic [7:0] sel8;

      vecs[0] = '{32'h4A920000, 0, 6, 16'h0004, 16'h0010, OP_AND, 16'h0020, 1, 1, 0};
      vecs[1] = '{32'h4A920000, 3, 9, 16'h0004, 16'h0010, OP_AND, 16'h0020, 1, 4, 0};
      vecs[2] = '{32'hF8000000, 0, 4, 16'h0000, 16'h0000, 5'd0,   16'h0000, 1, 1, 1};
      vecs[3] = '{mkIr(OP_NOP, 4'd0, 4'd0, 4'd0), 1, 5, 16'h0000, 16'h0000, 5'd0, 16'h0000, 1, 2, 0};
      vecs[4] = '{mkIr(OP_ADD, 4'd1, 4'd15, 4'd0), 0, 6, 16'h8000, 16'h0001, OP_ADD, 16'h0002, 1, 1, 0};
      vecs[5] = '{mkIr(OP_SUB, 4'd7, 4'd7, 4'd7), 1, 7, 16'h0080, 16'h0080, OP_SUB, 16'h0080, 1, 2, 0};
      vecs[6] = '{mkIr(OP_OR, 4'd0, 4'd3, 4'd9), 2, 8, 16'h0008, 16'h0200, OP_OR, 16'h0001, 1, 3, 0};
      vecs[7] = '{mkIr(5'b00000, 4'd3, 4'd3, 4'd3), 0, 4, 16'h0000, 16'h0000, 5'd0, 16'h0000, 1, 1, 1};

      reset_n = 1'b0;
      mbus.run = 1'b0; mbus.mem_rdy = 1'b1; mbus.ir = '0;
      sbus.run = 1'b0; sbus.mem_rdy = 1'b1; sbus.ir = '0;
      #13;
      checkOutput("resetMain", sampleMain(), 64'd0);
      checkOutput("resetSmall", 64'({sbus.pc_out, sbus.reg_in_sel, sbus.halted}), 64'd0);

      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      mbus.run = 1'b1;
      #1;
      checkOutput("idleBeforeRun", sampleMain(), 64'd0);

      for (int v = 0; v < 8; v++) applyStimulus(v);

      fsmIdle = 1'b0;
      planInstr(mkIr(OP_ADD, 4'd3, 4'd1, 4'd2), 0, 1'b1);
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 6))
            0: op = OP_ADD;
            1: op = OP_SUB;
            2: op = OP_AND;
            3: op = OP_OR;
            4: op = OP_NOP;
            default: begin
               op = 5'($urandom);
               if (op == OP_HALT) op = 5'b11111;
            end
         endcase
         planInstr({op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)},
                   int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
      end
      planInstr(32'hD8000000, 1, 1'b0);
      runPlan();

      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("haltReset", sampleMain(), 64'd0);
      @(negedge clk);
      mbus.run = 1'b0; mbus.mem_rdy = 1'b1;
      reset_n = 1'b1;
      #1;
      checkOutput("haltReleased", sampleMain(), 64'd0);

      @(negedge clk);
      mbus.run = 1'b1;
      mbus.ir  = mkIr(OP_ADD, 4'd2, 4'd3, 4'd4);
      repeat (5) @(posedge clk);
      #2;
      o = sampleMain();
      checkOutput("preRstT4", 64'({o.zIn, o.aluOp, o.outSel}), 64'({1'b1, OP_ADD, 16'h0010}));
      reset_n = 1'b0;
      mbus.run = 1'b0;
      #1;
      checkOutput("rstMidT4", sampleMain(), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("idleAfterRst", sampleMain(), 64'd0);

      sbus.ir = {OP_ADD, 4'd9, 4'd1, 4'd2, 15'd0};
      sbus.mem_rdy = 1'b1;
      sbus.run = 1'b1;
      @(posedge clk);
      ill8 = 0; sel8 = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         ill8 += int'(sbus.illegal);
         sel8 |= sbus.reg_in_sel;
      end
      checkOutput("n8_illegalRa9", 64'(ill8), 64'd1);
      checkOutput("n8_noWriteRa9", 64'(sel8), 64'd0);
      sbus.ir = mkIr(OP_ADD, 4'd3, 4'd1, 4'd2);
      ill8 = 0; sel8 = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 1) sbus.run = 1'b0;
         #1;
         ill8 += int'(sbus.illegal);
         sel8 |= sbus.reg_in_sel;
      end
      checkOutput("n8_addInSel", 64'(sel8), 64'h08);
      checkOutput("n8_addLegal", 64'(ill8), 64'd0);
      @(negedge clk);
      #1;
      checkOutput("n8_idleAfter", 64'({sbus.pc_out, sbus.reg_in_sel, sbus.reg_out_sel}), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, errCount);
      $finish;
   end

endmodule
